// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------+
// | alu_pkg : opcode map, flag bit positions and CMP result codes         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_SHL  = 4'h2,
    OP_SHR  = 4'h3,
    OP_CMP  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_NAND = 4'h8,
    OP_NOR  = 4'h9,
    OP_XNOR = 4'hA,
    OP_INV  = 4'hB,
    OP_NEG  = 4'hC,
    OP_STO  = 4'hD,
    OP_SWP  = 4'hE,
    OP_LOAD = 4'hF
  } opcode_t;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // CMP_LT is sign-extended to all-ones when cast to the datapath width
  localparam int CMP_EQ = 0;
  localparam int CMP_GT = 1;
  localparam int CMP_LT = -1;

endpackage

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// +----------------------------------------------------------------------+
// | alu_exec_unit : combinational op decode -> result, next A/B, flags   |
// | Optional: ALU_SAT_EN saturates ADD/SUB/NEG on signed overflow        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] b_next,
  output logic [3:0]       flags
);

  localparam int M = WIDTH - 1;
  localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef ALU_SAT_EN
  localparam logic [WIDTH-1:0] MAX_S = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  opcode_t          op_e;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] neg;
  logic [WIDTH:0]   shl_t;
  logic [WIDTH:0]   shr_t;
  logic             shift_big;
  logic [WIDTH-1:0] r_raw;
  logic             c;
  logic             v;
  logic             keep_a;
  logic             a_from_b;

  assign op_e      = opcode_t'(op);
  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign neg       = '0 - a;
  // One guard bit on the far side of each shift captures the last bit shifted out
  assign shl_t     = {1'b0, a} << b;
  assign shr_t     = {a, 1'b0} >> b;
  assign shift_big = (b >= WIDTH'(WIDTH));

  always_comb begin
    r_raw    = '0;
    c        = 1'b0;
    v        = 1'b0;
    keep_a   = 1'b0;
    a_from_b = 1'b0;
    b_next   = b;
    case (op_e)
      OP_ADD: begin
        r_raw = sum[WIDTH-1:0];
        c     = sum[WIDTH];
        v     = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      OP_SUB: begin
        r_raw = diff[WIDTH-1:0];
        c     = diff[WIDTH];
        v     = (a[M] != b[M]) && (diff[M] != a[M]);
      end
      OP_SHL: begin
        if (b == '0) begin
          r_raw = a;
        end else if (!shift_big) begin
          r_raw = shl_t[WIDTH-1:0];
          c     = shl_t[WIDTH];
        end
      end
      OP_SHR: begin
        if (b == '0) begin
          r_raw = a;
        end else if (!shift_big) begin
          r_raw = shr_t[WIDTH:1];
          c     = shr_t[0];
        end
      end
      OP_CMP: begin
        keep_a = 1'b1;
        c      = diff[WIDTH];
        if (a == b)            r_raw = WIDTH'(CMP_EQ);
        else if (diff[WIDTH])  r_raw = WIDTH'(CMP_LT);
        else                   r_raw = WIDTH'(CMP_GT);
      end
      OP_AND:  r_raw = a & b;
      OP_OR:   r_raw = a | b;
      OP_XOR:  r_raw = a ^ b;
      OP_NAND: r_raw = ~(a & b);
      OP_NOR:  r_raw = ~(a | b);
      OP_XNOR: r_raw = ~(a ^ b);
      OP_INV:  r_raw = ~a;
      OP_NEG: begin
        r_raw = neg;
        c     = (a != '0);
        v     = (a == MIN_S);
      end
      OP_STO: begin
        r_raw  = a;
        keep_a = 1'b1;
        b_next = a;
      end
      OP_SWP: begin
        r_raw    = b;
        a_from_b = 1'b1;
        b_next   = a;
      end
      OP_LOAD: r_raw = data_in;
      default: r_raw = '0;
    endcase

    r = r_raw;
`ifdef ALU_SAT_EN
    // Only ADD/SUB/NEG raise V; true sign of an ADD/SUB overflow is A's sign, NEG overflow is positive
    if (v) r = (a[M] && (op_e != OP_NEG)) ? MIN_S : MAX_S;
`endif

    if (a_from_b)    a_next = b;
    else if (keep_a) a_next = a;
    else             a_next = r;

    flags        = 4'b0000;
    flags[FLG_N] = r[M];
    flags[FLG_Z] = (r == '0);
    flags[FLG_C] = c;
    flags[FLG_V] = v;
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq_core.sv
// +----------------------------------------------------------------------+
// | alu_seq_core : registered ALU with A/B operands and one output slot  |
// | Optional: ALU_SAT_EN (saturating ADD/SUB/NEG in alu_exec_unit)       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] exec_r;
  logic [WIDTH-1:0] exec_a;
  logic [WIDTH-1:0] exec_b;
  logic [3:0]       exec_flags;
  logic             accept;

  alu_exec_unit #(
    .WIDTH (WIDTH)
  ) u_exec (
    .op      (op),
    .a       (a_q),
    .b       (b_q),
    .data_in (data_in),
    .r       (exec_r),
    .a_next  (exec_a),
    .b_next  (exec_b),
    .flags   (exec_flags)
  );

  // Single slot: free when empty or being drained this cycle
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    y_d         = y_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      a_d         = exec_a;
      b_d         = exec_b;
      y_d         = exec_r;
      flags_d     = exec_flags;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      y_q         <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      y_q         <= y_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign flags     = flags_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_core.sv
// +----------------------------------------------------------------------+
// | tb_alu_seq_core : directed self-checking bench for alu_seq_core      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_alu_seq_core;
  import alu_pkg::*;

  localparam int WIDTH = 8;

`ifdef ALU_SAT_EN
  localparam logic [7:0] ADD_OVF_Y = 8'h7F;
  localparam logic [3:0] ADD_OVF_F = 4'b0001;
  localparam logic [7:0] NEG_MIN_Y = 8'h7F;
  localparam logic [3:0] NEG_MIN_F = 4'b0011;
`else
  localparam logic [7:0] ADD_OVF_Y = 8'h80;
  localparam logic [3:0] ADD_OVF_F = 4'b1001;
  localparam logic [7:0] NEG_MIN_Y = 8'h80;
  localparam logic [3:0] NEG_MIN_F = 4'b1011;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [3:0]       flags;

  int vecs = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_seq_core #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [7:0] ey, input logic [3:0] ef,
                         input logic [7:0] ea, input logic [7:0] eb);
    chk({tag, " y"}, 32'(y), 32'(ey));
    chk({tag, " flags"}, 32'(flags), 32'(ef));
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " A"}, 32'(dut.a_q), 32'(ea));
    chk({tag, " B"}, 32'(dut.b_q), 32'(eb));
  endtask

  // Drive on the falling edge, leave the bench #1 after the accepting edge
  task automatic issue(input opcode_t o, input logic [7:0] d);
    @(negedge clk);
    op       = o;
    data_in  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'h0;
    data_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset y", 32'(y), 32'h0);
    chk("reset flags", 32'(flags), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset A", 32'(dut.a_q), 32'h0);
    chk("reset B", 32'(dut.b_q), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    issue(OP_LOAD, 8'h05); issue(OP_STO, 8'h00); issue(OP_LOAD, 8'h03);
    issue(OP_ADD, 8'h00);
    chk_res("add basic", 8'h08, 4'b0000, 8'h08, 8'h05);

    issue(OP_LOAD, 8'h7F); issue(OP_STO, 8'h00); issue(OP_LOAD, 8'h01);
    issue(OP_ADD, 8'h00);
    chk_res("add ovf", ADD_OVF_Y, ADD_OVF_F, ADD_OVF_Y, 8'h7F);

    issue(OP_LOAD, 8'h05); issue(OP_STO, 8'h00); issue(OP_LOAD, 8'h03);
    issue(OP_SUB, 8'h00);
    chk_res("sub borrow", 8'hFE, 4'b1010, 8'hFE, 8'h05);
    issue(OP_CMP, 8'h00);
    chk_res("cmp gt", 8'h01, 4'b0000, 8'hFE, 8'h05);
    issue(OP_LOAD, 8'h05); issue(OP_CMP, 8'h00);
    chk_res("cmp eq", 8'h00, 4'b0100, 8'h05, 8'h05);
    issue(OP_LOAD, 8'h02); issue(OP_CMP, 8'h00);
    chk_res("cmp lt", 8'hFF, 4'b1010, 8'h02, 8'h05);

    issue(OP_LOAD, 8'h01); issue(OP_STO, 8'h00); issue(OP_LOAD, 8'h81);
    issue(OP_SHL, 8'h00);
    chk_res("shl 1", 8'h02, 4'b0010, 8'h02, 8'h01);
    issue(OP_LOAD, 8'h09); issue(OP_STO, 8'h00); issue(OP_SHL, 8'h00);
    chk_res("shl big", 8'h00, 4'b0100, 8'h00, 8'h09);
    issue(OP_LOAD, 8'h80); issue(OP_NEG, 8'h00);
    chk_res("neg min", NEG_MIN_Y, NEG_MIN_F, NEG_MIN_Y, 8'h09);

    issue(OP_LOAD, 8'h03); issue(OP_STO, 8'h00); issue(OP_LOAD, 8'h8C);
    issue(OP_SHR, 8'h00);
    chk_res("shr 3", 8'h11, 4'b0010, 8'h11, 8'h03);
    issue(OP_LOAD, 8'h00); issue(OP_STO, 8'h00); issue(OP_LOAD, 8'hA5);
    issue(OP_SHL, 8'h00);
    chk_res("shl 0", 8'hA5, 4'b1000, 8'hA5, 8'h00);

    issue(OP_LOAD, 8'h3C); issue(OP_STO, 8'h00); issue(OP_LOAD, 8'h0F);
    issue(OP_XOR, 8'h00);
    chk_res("xor", 8'h33, 4'b0000, 8'h33, 8'h3C);
    issue(OP_NAND, 8'h00);
    chk_res("nand", 8'hCF, 4'b1000, 8'hCF, 8'h3C);
    issue(OP_INV, 8'h00);
    chk_res("inv", 8'h30, 4'b0000, 8'h30, 8'h3C);
    issue(OP_LOAD, 8'hF0); issue(OP_ADD, 8'h00);
    chk_res("add carry", 8'h2C, 4'b0010, 8'h2C, 8'h3C);

    issue(OP_LOAD, 8'h34); issue(OP_STO, 8'h00); issue(OP_LOAD, 8'h12);
    issue(OP_SWP, 8'h00);
    chk_res("swp", 8'h34, 4'b0000, 8'h34, 8'h12);

    // Stall: sink refuses while a new op is offered
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = OP_LOAD;
    data_in   = 8'h55;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk_res("stall hold", 8'h34, 4'b0000, 8'h34, 8'h12);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("drain in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_res("drain+accept", 8'h55, 4'b0000, 8'h55, 8'h12);
    @(posedge clk);
    #1;
    chk("drained out_valid", 32'(out_valid), 32'd0);

    // Reset while a result is held under back-pressure
    issue(OP_LOAD, 8'h77);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_res("pre-rst hold", 8'h77, 4'b0000, 8'h77, 8'h12);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst y", 32'(y), 32'h0);
    chk("rst flags", 32'(flags), 32'h0);
    chk("rst A", 32'(dut.a_q), 32'h0);
    chk("rst B", 32'(dut.b_q), 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
